seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Sequential unsigned restoring divider for the operating unit. It is the inverse path of the 2N-bit multiply/accumulate datapath.
- Divides a 2N-bit dividend (register A/B width) by an N-bit divisor. Produces an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Started by a single-cycle request from the control unit. Reports completion with a one-cycle done pulse; results are held until the next operation.

Parameters:
N, 4, divisor/quotient/remainder width; dividend width is 2N; N >= 2

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request; sampled only in IDLE
dividend  in  2N  unsigned dividend, captured on accepted start
divisor  in  N  unsigned divisor, captured on accepted start
quotient  out  N  quotient, valid from done cycle until next accepted start
remainder  out  N  remainder, same validity as quotient
busy  out  1  high in CALC
done  out  1  one-cycle pulse in DONE
err  out  1  error flag, valid with done (see Optional Feature)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- rst=1 at a clock edge, including mid-operation: state<=IDLE, counter<=0, quotient=0, remainder=0, busy=0, done=0, err=0. Operands are discarded. rst has priority over start.
- Internal registers:
  - R: 2N-bit shift register, {upper N, lower N}.
  - carry: 1 bit, the bit shifted out of R.
  - D: N-bit captured divisor.
  - cnt: ceil(log2(N+1)) bits.
- State machine IDLE -> CALC -> DONE -> IDLE:
  - IDLE: busy=0, done=0. If start=1: R<=dividend, D<=divisor, cnt<=N, go CALC. Otherwise stay.
  - CALC: busy=1. Each cycle does one step:
    - T = {carry', R[2N-1:N]} after R shifts left by 1; the vacated R[0] becomes 0.
    - If T >= {0,D} (N+1-bit unsigned compare): R[2N-1:N] <= T - D (low N bits), R[0] <= 1.
    - Otherwise R[0] stays 0.
    - cnt decrements. When cnt reaches 1, go DONE after this step.
  - DONE: for exactly one cycle, done=1 and busy=0. quotient<=R[N-1:0], remainder<=R[2N-1:N]. Always go to IDLE next.
- Latency: start accepted at edge k; busy high during cycles k+1..k+N; done high in cycle k+N+1.
- quotient and remainder change only when entering DONE or on reset. They are stable in IDLE.
- start while busy or during DONE: ignored, with no queuing. start held high continuously: a new operation is accepted in each IDLE cycle, so back-to-back period is N+2 cycles.
- Operand inputs need only be valid on the accepted start edge. Later changes have no effect.
- Quotient overflow (dividend[2N-1:N] >= divisor, divisor != 0) and divide-by-zero are undefined mathematically. Without the optional feature, outputs are exactly what N steps of the algorithm above produce.
  - Divisor 0 therefore gives quotient = all ones and remainder = dividend[N-1:0].

Optional Feature:
- Macro: SEQ_DIV_CHECK_EN.
- Defined: in IDLE on an accepted start, if divisor == 0 or dividend[2N-1:N] >= divisor, the block skips CALC and goes straight to DONE at the next edge.
  - In DONE: done=1, err=1, quotient = all ones, remainder = dividend[N-1:0] (captured).
  - Latency is 1 cycle. busy is never asserted for that operation.
  - err clears when the next start is accepted or on rst. Otherwise err=0 with done.
- Not defined: no check logic. err is tied to 0, and all operands take the full N-cycle path.

Test Plan:
1. N=4, rst high 2 cycles, then dividend=0x64 (100), divisor=7, start 1 cycle -> busy for 4 cycles; done in cycle k+5 with quotient=14, remainder=2, err=0.
2. dividend=0x23, divisor=5 -> quotient=7, remainder=0. Change the dividend input while busy -> results unchanged.
3. start held high for 3 operations (0x64/7, 0x0F/3, 0x3F/9) -> done pulses spaced 6 cycles apart; results 14r2, 5r0, 7r0.
4. Assert rst in the 2nd CALC cycle of 0x64/7 -> next cycle busy=0, done=0, quotient=0, remainder=0. A following 0x23/5 completes normally with 7r0.
5. dividend=0x45, divisor=0:
   - With SEQ_DIV_CHECK_EN: done 1 cycle after start, err=1, quotient=0xF, remainder=0x5, busy never high.
   - Without it: done after N+1 cycles, quotient=0xF, remainder=0x5, err=0.
6. With SEQ_DIV_CHECK_EN, dividend=0xA0, divisor=3 -> err=1, 1-cycle latency. Then 0x64/7 -> err=0, quotient=14, remainder=2.

Source files
------------

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define SEQ_DIV_CHECK_EN to flag divide-by-zero and quotient overflow with a 1-cycle err completion.
module seq_div #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*N-1:0] r;
  logic [2*N-1:0] r_step;
  logic [N-1:0]   d;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic [N:0]     t;
  logic [N:0]     t_sub;
  logic           op_err;
  logic           last_step;

  // Handshake: start is a request honoured only in IDLE (no queuing); done is a
  // one-cycle completion pulse, and quotient/remainder/err hold until the next accepted start.

  // One restoring step: shift R left, trial-subtract D from the (N+1)-bit upper window.
  always_comb begin
    carry  = r[2*N-1];
    t      = {carry, r[2*N-2:N-1]};
    t_sub  = t - {1'b0, d};
    r_step = {t[N-1:0], r[N-2:0], 1'b0};
    if (t >= {1'b0, d}) begin
      r_step = {t_sub[N-1:0], r[N-2:0], 1'b1};
    end
  end

`ifdef SEQ_DIV_CHECK_EN
  assign op_err = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
`else
  assign op_err = 1'b0;
`endif

  assign last_step = (cnt == CW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = op_err ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            r   <= dividend;
            d   <= divisor;
            cnt <= CW'(N);
            if (op_err) begin
              quotient  <= '1;
              remainder <= dividend[N-1:0];
            end
          end
        end
        CALC: begin
          r   <= r_step;
          cnt <= cnt - 1'b1;
          // Results are published on the edge that enters DONE.
          if (last_step) begin
            quotient  <= r_step[N-1:0];
            remainder <= r_step[2*N-1:N];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIV_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      err_q <= op_err;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed scenarios plus random operands against an arithmetic model.
module tb_seq_div;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  seq_div #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division for well-formed operands; fixed values for the ill-posed ones.
  task automatic model(input logic [W-1:0] dd, input logic [N-1:0] dv,
                       output logic [N-1:0] eq, output logic [N-1:0] er,
                       output logic ee, output int elat);
    int hi, lo, a, b;
    a  = int'(dd);
    b  = int'(dv);
    hi = a / (1 << N);
    lo = a % (1 << N);
    ee   = 1'b0;
    elat = N + 1;
    if (b == 0 || hi >= b) begin
      eq = '1;
      er = N'(lo);
`ifdef SEQ_DIV_CHECK_EN
      ee   = 1'b1;
      elat = 1;
`endif
    end else begin
      eq = N'(a / b);
      er = N'(a % b);
    end
  endtask

  // driver: one start pulse, operands scrambled while the operation runs
  task automatic run_op(input logic [W-1:0] dd, input logic [N-1:0] dv);
    logic [N-1:0] eq, er;
    logic         ee;
    int           elat, lat, nbusy;
    string        tag;
    tag = $sformatf("%0h/%0h", dd, dv);
    model(dd, dv, eq, er, ee, elat);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat <= N + 5) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
      dividend = W'($urandom);
      divisor  = N'($urandom);
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " done"}, done, 1);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " busy_cycles"}, nbusy, elat - 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " err"}, err, ee);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " quotient_hold"}, quotient, eq);
    check({tag, " remainder_hold"}, remainder, er);
    check({tag, " err_hold"}, err, ee);
  endtask

  logic [W-1:0] held_dd [3] = '{8'h64, 8'h0F, 8'h3F};
  logic [N-1:0] held_dv [3] = '{4'd7, 4'd3, 4'd9};
  logic [N-1:0] held_q  [3] = '{4'd14, 4'd5, 4'd7};
  logic [N-1:0] held_r  [3] = '{4'd2, 4'd0, 4'd0};

  initial begin
    int           prev, to;
    logic [N-1:0] rdv, rhi, rlo;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset err", err, 0);
    rst = 1'b0;

    run_op(8'h64, 4'd7);
    run_op(8'h23, 4'd5);

    // start held high: back-to-back operations
    @(negedge clk);
    dividend = held_dd[0];
    divisor  = held_dv[0];
    start    = 1'b1;
    prev     = 0;
    for (int i = 0; i < 3; i++) begin
      to = 0;
      @(negedge clk);
      while (!done && to < 40) begin
        @(negedge clk);
        to++;
      end
      check("held done", done, 1);
      check("held quotient", quotient, held_q[i]);
      check("held remainder", remainder, held_r[i]);
      if (i > 0) check("held period", cyc_cnt - prev, N + 2);
      prev = cyc_cnt;
      if (i < 2) begin
        dividend = held_dd[i+1];
        divisor  = held_dv[i+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    @(negedge clk);
    check("held idle after", busy, 0);

    // reset in the second CALC cycle
    @(negedge clk);
    dividend = 8'h64;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrst busy before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    run_op(8'h23, 4'd5);

    run_op(8'h45, 4'd0);
`ifdef SEQ_DIV_CHECK_EN
    run_op(8'hA0, 4'd3);
    run_op(8'h64, 4'd7);
`endif

    for (int i = 0; i < 40; i++) begin
      rdv = N'($urandom);
      rlo = N'($urandom);
`ifdef SEQ_DIV_CHECK_EN
      rhi = N'($urandom);
`else
      if (rdv == 0) rhi = N'($urandom);
      else rhi = N'($urandom_range(0, int'(rdv) - 1));
`endif
      run_op({rhi, rlo}, rdv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
